// File: rtl/stmt_lowerer_pkg.sv
// Shared types and helpers for the range-dispatch lowering fixture.
// Bound vectors are zero-extended to a fixed width so one helper serves any parameterisation.
package stmt_lowerer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        EMIT = 2'd2
    } dispatch_state_e;

    localparam int BOUND_VEC_W = 1024;
    localparam int BOUND_W     = 32;

    // Returns field k of width w from a packed bound vector.
    function automatic logic [BOUND_W-1:0] bound_at(input logic [BOUND_VEC_W-1:0] vec,
                                                    input int k, input int w);
        logic [BOUND_VEC_W-1:0] shifted;
        logic [BOUND_W-1:0]     mask;
        shifted = vec >> (k * w);
        mask    = (w >= BOUND_W) ? '1 : ((BOUND_W'(1) << w) - BOUND_W'(1));
        return shifted[BOUND_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/stmt_lowerer_range_match.sv
// Combinational range classifier: the lowest-index channel whose inclusive range holds the select wins.
module stmt_lowerer_range_match
    import stmt_lowerer_pkg::*;
#(
    parameter int SEL_W      = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DEFAULT_CH = 0
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_CH*SEL_W-1:0] i_lo_bounds,
    input  logic [NUM_CH*SEL_W-1:0] i_hi_bounds,
    output logic [CH_W-1:0]         o_ch,
    output logic                    o_miss
);

    // Descending walk: later (lower-index) hits overwrite earlier ones.
    always_comb begin : match_loop
        logic [SEL_W-1:0] v_lo;
        logic [SEL_W-1:0] v_hi;
        o_ch   = CH_W'(DEFAULT_CH);
        o_miss = 1'b1;
        v_lo   = '0;
        v_hi   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            v_lo = SEL_W'(bound_at(BOUND_VEC_W'(i_lo_bounds), k, SEL_W));
            v_hi = SEL_W'(bound_at(BOUND_VEC_W'(i_hi_bounds), k, SEL_W));
            // An inverted range is treated as empty rather than relying on tool-specific inside semantics.
            if ((v_lo <= v_hi) && (i_sel inside {[v_lo:v_hi]})) begin
                o_ch   = CH_W'(k);
                o_miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stmt_lowerer_range_dispatch.sv
// Range-dispatch block: classify on accept, hold HOLD_CYCLES, emit over valid/ready, count emits.
module stmt_lowerer_range_dispatch
    import stmt_lowerer_pkg::*;
#(
    parameter int                       SEL_W       = 8,
    parameter int                       DATA_W      = 8,
    parameter int                       NUM_CH      = 4,
    parameter int                       CNT_W       = 16,
    parameter int                       HOLD_CYCLES = 3,
    parameter logic [SEL_W-1:0]         SEL_MASK    = 8'hFF,
    parameter logic [NUM_CH*SEL_W-1:0]  LO_BOUNDS   = {8'h30, 8'h1D, 8'h10, 8'h00},
    parameter logic [NUM_CH*SEL_W-1:0]  HI_BOUNDS   = {8'h4F, 8'h23, 8'h1F, 8'h00},
    parameter int                       DEFAULT_CH  = 0,
    localparam int                      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_miss,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    dispatch_state_e     r_state;
    dispatch_state_e     w_next_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [CH_W-1:0]     r_ch;
    logic                r_miss_flag;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_hit [NUM_CH];
    logic [CNT_W-1:0]    r_miss_cnt;
    logic [SEL_W-1:0]    w_sel;
    logic [CH_W-1:0]     w_ch;
    logic                w_miss;
    logic                w_accept;
    logic                w_emit;

    assign w_sel    = in_sel & SEL_MASK;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = out_valid && out_ready;

    stmt_lowerer_range_match #(
        .SEL_W      (SEL_W),
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .DEFAULT_CH (DEFAULT_CH)
    ) u_match (
        .i_sel       (w_sel),
        .i_lo_bounds (LO_BOUNDS),
        .i_hi_bounds (HI_BOUNDS),
        .o_ch        (w_ch),
        .o_miss      (w_miss)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = (HOLD_CYCLES == 0) ? EMIT : BUSY;
            BUSY:    if (r_hold == '0) w_next_state = EMIT;
            EMIT:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= HOLD_INIT;
        end else if ((r_state == BUSY) && (r_hold != '0)) begin
            r_hold <= r_hold - HOLD_W'(1);
        end
    end

    // Classification and payload are frozen at accept and only move on the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_miss_flag <= 1'b0;
            r_data      <= '0;
        end else if (w_accept) begin
            r_ch        <= w_ch;
            r_miss_flag <= w_miss;
            r_data      <= in_data;
        end
    end

    assign out_ch   = r_ch;
    assign out_miss = r_miss_flag;
    assign out_data = r_data;

    // Clear has priority over a coincident emit; counts stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_miss_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) r_hit[k] <= '0;
        end else if (w_emit) begin
            if (r_miss_flag) begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if ((r_ch == CH_W'(k)) && (r_hit[k] != '1)) r_hit[k] <= r_hit[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) hit_cnt[k*CNT_W +: CNT_W] = r_hit[k];
    end

    assign miss_cnt = r_miss_cnt;

endmodule

// File: doc/stmt_lowerer_range_dispatch.md
# stmt_lowerer_range_dispatch

Parametrised, clocked successor to the combinational case/case-inside lowering fixtures. It classifies each accepted select word against NUM_CH programmable inclusive ranges, the `case ... inside` semantics generalised to N channels with lowest-index priority. A repeat-style hold counter delays the result by HOLD_CYCLES. The result is then emitted over a valid/ready handshake, and per-channel saturating hit counters and a miss counter are maintained. It sits in the convert test corpus as the sequential-lowering stress case: `always_ff`, an FSM, a `for` loop over channels, and `inside` ranges.

## Interface
- SEL_W, 8, select width
- DATA_W, 8, payload width
- NUM_CH, 4, channel count (≥1)
- CNT_W, 16, counter width
- HOLD_CYCLES, 3, delay cycles between accept and emit (0 allowed)
- SEL_MASK, 8'hFF, AND-mask applied to in_sel before matching
- LO_BOUNDS, {8'h30,8'h1D,8'h10,8'h00}, packed NUM_CH×SEL_W; channel k at [k*SEL_W +: SEL_W]
- HI_BOUNDS, {8'h4F,8'h23,8'h1F,8'h00}, same packing, inclusive upper bounds
- DEFAULT_CH, 0, channel reported on miss
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_sel  in  SEL_W  select word
- in_data  in  DATA_W  payload
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_ch  out  $clog2(NUM_CH) (min 1)  matched channel
- out_miss  out  1  no range matched
- out_data  out  DATA_W  captured payload
- cnt_clr  in  1  synchronous clear of all counters
- hit_cnt  out  NUM_CH×CNT_W  per-channel emit counts, channel k at [k*CNT_W +: CNT_W]
- miss_cnt  out  CNT_W  emitted-miss count

## Operation
- Match: m = in_sel & SEL_MASK. Channel k hits when LO[k] ≤ m ≤ HI[k], compared unsigned. The lowest hitting k wins. No hit gives ch=DEFAULT_CH and miss=1. LO>HI for a channel means that channel never matches.
- FSM states: IDLE, BUSY, EMIT.
  - IDLE: in_valid&&in_ready captures data, ch and miss.
    - HOLD_CYCLES=0: go to EMIT.
    - Otherwise: go to BUSY with hold_cnt=HOLD_CYCLES-1.
  - BUSY: if hold_cnt==0 go to EMIT, else decrement hold_cnt. in_valid is ignored.
  - EMIT: out_valid=1. out_valid&&out_ready returns to IDLE. in_valid is ignored.
- Counters update on the emit handshake only:
  - hit_cnt[out_ch] increments when miss=0.
  - miss_cnt increments when miss=1.
  - Counters saturate at all-ones and do not wrap.
- cnt_clr zeroes every counter. If it coincides with a handshake, the clear wins and the counter reads 0.
- Classification is fixed at capture. Classification and payload registers change only on accept.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_ch=0, out_miss=0, out_data=0, all counters 0.
- Reset mid-operation, whether in BUSY or EMIT, aborts the transaction. No out_valid follows and no counter changes.
- Request accepted in cycle 0: out_valid is high from cycle 1+HOLD_CYCLES. With the default, that is cycle 4.
- Under backpressure, out_valid, out_ch, out_miss and out_data hold stable until the handshake.
- in_ready rises in the cycle after the emit handshake. There is no bypass. Peak throughput is one request per HOLD_CYCLES+2 cycles.
- Counter outputs reflect a handshake in the following cycle.

## Structure
- Package stmt_lowerer_pkg holds:
  - the state enum typedef (dispatch_state_e: IDLE, BUSY, EMIT);
  - a function that extracts a bound from a packed parameter vector.
- Sub-module stmt_lowerer_range_match: combinational. Inputs are the masked select, LO_BOUNDS and HI_BOUNDS. Outputs are ch and miss. It is built as a descending `for` loop using `inside [LO:HI]`, so the lowest index wins.
- The top level holds the FSM, hold counter, capture registers and counters.

## Test plan
- Reset: hold rst for 2 cycles. Required after release: in_ready=1, out_valid=0, all counters 0.
- Basic hit: in_sel=8'h15, in_data=8'hA5, out_ready=1. Required: out_valid in cycle 4 with out_ch=1, out_miss=0, out_data=8'hA5; afterwards hit_cnt[1]=1.
- Priority and boundaries:
  - in_sel=8'h1E gives ch=1 (overlaps channel 2).
  - 8'h21 gives ch=2.
  - 8'h00 gives ch=0.
  - 8'h4F gives ch=3.
  - 8'h50 gives a miss.
- Miss: in_sel=8'h80 gives out_ch=0, out_miss=1, miss_cnt=1, hit counts unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT while driving in_valid=1. Required: outputs stable, in_ready=0, no second capture; one emit only after out_ready=1.
- Abort and clear:
  - Assert rst in BUSY: no out_valid follows and counters stay 0.
  - cnt_clr coincident with a hit handshake leaves hit_cnt=0.
  - Preload via CNT_W=2: four hits on one channel leave that count at 3.
